// File: rtl/diad_trace_pkg.sv
// Shared types and constants for the retirement trace buffer.
// TRACE_TIMESTAMP_EN adds a per-entry cycle stamp to the stored entry.
package diad_trace_pkg;

    localparam int unsigned TRACE_STAMP_W = 32;
    localparam int unsigned DROP_W        = 16;
    localparam int unsigned WADDR_W       = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_POST  = 2'd2,
        ST_DONE  = 2'd3
    } trace_state_t;

    // Fixed-width part of a stored entry. PC, instruction and writeback data
    // widths are module parameters, so the top packs those around this struct.
    typedef struct packed {
`ifdef TRACE_TIMESTAMP_EN
        logic [TRACE_STAMP_W-1:0] stamp;
`endif
        logic                     we;
        logic [WADDR_W-1:0]       waddr;
    } trace_entry_t;

    // Saturating increment for the drop counter.
    function automatic logic [DROP_W-1:0] drop_inc(input logic [DROP_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/trace_ram.sv
// Entry storage for the retirement trace buffer: one synchronous write port,
// one asynchronous read port. Contents are not reset.
module trace_ram #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write the addressed entry on the rising edge.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/retire_trace_buf.sv
// Retirement trace buffer: captures retired instructions into a circular
// buffer while armed, freezes the pre-trigger history on a PC match, captures
// a programmable number of post-trigger retirements, then holds for readout.
// Optional macro TRACE_TIMESTAMP_EN adds a free-running cycle stamp per entry
// and the rd_stamp output.
module retire_trace_buf
    import diad_trace_pkg::*;
#(
    parameter int unsigned PC_W    = 24,
    parameter int unsigned INSTR_W = 24,
    parameter int unsigned DATA_W  = 24,
    parameter int unsigned DEPTH   = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ret_valid,
    input  logic [PC_W-1:0]            ret_pc,
    input  logic [INSTR_W-1:0]         ret_instr,
    input  logic                       ret_we,
    input  logic [3:0]                 ret_waddr,
    input  logic [DATA_W-1:0]          ret_wdata,
    input  logic                       arm,
    input  logic [PC_W-1:0]            trig_pc,
    input  logic [7:0]                 post_cnt,
    output logic                       rd_valid,
    input  logic                       rd_ready,
    output logic [PC_W-1:0]            rd_pc,
    output logic [INSTR_W-1:0]         rd_instr,
    output logic                       rd_we,
    output logic [3:0]                 rd_waddr,
    output logic [DATA_W-1:0]          rd_wdata,
`ifdef TRACE_TIMESTAMP_EN
    output logic [TRACE_STAMP_W-1:0]   rd_stamp,
`endif
    output logic [1:0]                 state,
    output logic [$clog2(DEPTH):0]     level,
    output logic [DROP_W-1:0]          drop_cnt
);

    localparam int unsigned AW      = $clog2(DEPTH);
    localparam int unsigned LW      = AW + 1;
    localparam int unsigned SIDE_W  = $bits(trace_entry_t);
    localparam int unsigned ENTRY_W = PC_W + INSTR_W + DATA_W + SIDE_W;

    trace_state_t      state_q;
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [LW-1:0]     level_q;
    logic [DROP_W-1:0] drop_q;
    logic [7:0]        post_left;

`ifdef TRACE_TIMESTAMP_EN
    logic [TRACE_STAMP_W-1:0] stamp_q;
`endif

    logic full;
    logic head_valid;
    logic pop;
    logic store;
    logic drop;
    logic adv_head;

    trace_entry_t       wr_side;
    trace_entry_t       rd_side;
    logic [ENTRY_W-1:0] wr_entry;
    logic [ENTRY_W-1:0] rd_entry;
    logic [PC_W-1:0]    rd_pc_raw;
    logic [INSTR_W-1:0] rd_instr_raw;
    logic [DATA_W-1:0]  rd_wdata_raw;

    assign full       = (level_q == LW'(DEPTH));
    assign head_valid = (level_q != '0) && (state_q != ST_ARMED);
    assign pop        = head_valid && rd_ready;

    // Decide per cycle whether the retirement is stored or dropped and whether
    // the head pointer moves (consumer pop, or overwrite of the oldest entry
    // while armed). arm takes precedence over both retirement and pop.
    always_comb begin
        store    = 1'b0;
        drop     = 1'b0;
        adv_head = 1'b0;
        if (!arm) begin
            adv_head = pop;
            unique case (state_q)
                ST_ARMED: begin
                    if (ret_valid) begin
                        store    = 1'b1;
                        adv_head = full;
                    end
                end
                ST_POST: begin
                    if (ret_valid) begin
                        if (!full || pop) begin
                            store = 1'b1;
                        end else begin
                            drop = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        wr_side       = '0;
        wr_side.we    = ret_we;
        wr_side.waddr = ret_waddr;
`ifdef TRACE_TIMESTAMP_EN
        wr_side.stamp = stamp_q;
`endif
    end

    assign wr_entry = {ret_pc, ret_instr, ret_wdata, wr_side};

    trace_ram #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_ram (
        .clk   (clk),
        .we    (store && !rst),
        .waddr (wr_ptr),
        .wdata (wr_entry),
        .raddr (rd_ptr),
        .rdata (rd_entry)
    );

    assign {rd_pc_raw, rd_instr_raw, rd_wdata_raw, rd_side} = rd_entry;

    // Capture FSM with pointer, level, drop and post-trigger counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level_q   <= '0;
            drop_q    <= '0;
            post_left <= '0;
        end else if (arm) begin
            state_q <= ST_ARMED;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
            drop_q  <= '0;
        end else begin
            if (store) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (adv_head) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (store && !adv_head) begin
                level_q <= level_q + 1'b1;
            end else if (!store && adv_head) begin
                level_q <= level_q - 1'b1;
            end
            if (drop) begin
                drop_q <= drop_inc(drop_q);
            end
            unique case (state_q)
                ST_ARMED: begin
                    if (ret_valid && (ret_pc == trig_pc)) begin
                        post_left <= post_cnt;
                        state_q   <= (post_cnt == '0) ? ST_DONE : ST_POST;
                    end
                end
                ST_POST: begin
                    if (ret_valid) begin
                        post_left <= post_left - 1'b1;
                        if (post_left == 8'd1) begin
                            state_q <= ST_DONE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef TRACE_TIMESTAMP_EN
    // Free-running cycle stamp, wraps at 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            stamp_q <= '0;
        end else begin
            stamp_q <= stamp_q + 1'b1;
        end
    end

    assign rd_stamp = head_valid ? rd_side.stamp : '0;
`endif

    assign rd_valid = head_valid;
    assign rd_pc    = head_valid ? rd_pc_raw    : '0;
    assign rd_instr = head_valid ? rd_instr_raw : '0;
    assign rd_we    = head_valid ? rd_side.we   : 1'b0;
    assign rd_waddr = head_valid ? rd_side.waddr : '0;
    assign rd_wdata = head_valid ? rd_wdata_raw : '0;
    assign state    = state_q;
    assign level    = level_q;
    assign drop_cnt = drop_q;

endmodule

// File: tb/tb_retire_trace_buf.sv
// Self-checking bench for retire_trace_buf: directed scenarios followed by
// randomized traffic, all compared against a queue-based reference model.
// Build with TRACE_TIMESTAMP_EN to also cover the cycle-stamp feature.
module tb_retire_trace_buf;

    localparam int PC_W    = 24;
    localparam int INSTR_W = 24;
    localparam int DATA_W  = 24;
    localparam int DEPTH   = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst;
    logic                ret_valid;
    logic [PC_W-1:0]     ret_pc;
    logic [INSTR_W-1:0]  ret_instr;
    logic                ret_we;
    logic [3:0]          ret_waddr;
    logic [DATA_W-1:0]   ret_wdata;
    logic                arm;
    logic [PC_W-1:0]     trig_pc;
    logic [7:0]          post_cnt;
    logic                rd_valid;
    logic                rd_ready;
    logic [PC_W-1:0]     rd_pc;
    logic [INSTR_W-1:0]  rd_instr;
    logic                rd_we;
    logic [3:0]          rd_waddr;
    logic [DATA_W-1:0]   rd_wdata;
`ifdef TRACE_TIMESTAMP_EN
    logic [31:0]         rd_stamp;
`endif
    logic [1:0]          state;
    logic [4:0]          level;
    logic [15:0]         drop_cnt;

    retire_trace_buf #(
        .PC_W    (PC_W),
        .INSTR_W (INSTR_W),
        .DATA_W  (DATA_W),
        .DEPTH   (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ret_valid (ret_valid),
        .ret_pc    (ret_pc),
        .ret_instr (ret_instr),
        .ret_we    (ret_we),
        .ret_waddr (ret_waddr),
        .ret_wdata (ret_wdata),
        .arm       (arm),
        .trig_pc   (trig_pc),
        .post_cnt  (post_cnt),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_pc     (rd_pc),
        .rd_instr  (rd_instr),
        .rd_we     (rd_we),
        .rd_waddr  (rd_waddr),
        .rd_wdata  (rd_wdata),
`ifdef TRACE_TIMESTAMP_EN
        .rd_stamp  (rd_stamp),
`endif
        .state     (state),
        .level     (level),
        .drop_cnt  (drop_cnt)
    );

    // Reference model: the buffer is a queue, oldest entry at the front.
    typedef struct {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
        logic               we;
        logic [3:0]         waddr;
        logic [DATA_W-1:0]  wdata;
        int unsigned        stamp;
    } ent_t;

    ent_t        mq[$];
    int          m_state;
    int          m_cnt;
    int          m_drop;
    int unsigned m_stamp;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    function automatic void model_edge();
        ent_t e;
        bit   pop;
        if (rst) begin
            mq.delete();
            m_state = 0;
            m_drop  = 0;
            m_cnt   = 0;
            m_stamp = 0;
            return;
        end
        e.pc    = ret_pc;
        e.instr = ret_instr;
        e.we    = ret_we;
        e.waddr = ret_waddr;
        e.wdata = ret_wdata;
        e.stamp = m_stamp;
        m_stamp++;
        if (arm) begin
            mq.delete();
            m_drop  = 0;
            m_state = 1;
            return;
        end
        pop = (mq.size() > 0) && (m_state != 1) && rd_ready;
        if (m_state == 1) begin
            if (ret_valid) begin
                if (mq.size() == DEPTH) void'(mq.pop_front());
                mq.push_back(e);
                if (ret_pc == trig_pc) begin
                    m_cnt   = post_cnt;
                    m_state = (post_cnt == 0) ? 3 : 2;
                end
            end
        end else begin
            if (pop) void'(mq.pop_front());
            if (m_state == 2 && ret_valid) begin
                if (mq.size() < DEPTH) mq.push_back(e);
                else if (m_drop < 65535) m_drop++;
                m_cnt--;
                if (m_cnt == 0) m_state = 3;
            end
        end
    endfunction

    task automatic check_outputs();
        bit v;
        v = (mq.size() > 0) && (m_state != 1);
        check("state", 64'(state), 64'(m_state));
        check("level", 64'(level), 64'(mq.size()));
        check("rd_valid", 64'(rd_valid), 64'(v));
        check("drop_cnt", 64'(drop_cnt), 64'(m_drop));
        if (v) begin
            check("rd_pc", 64'(rd_pc), 64'(mq[0].pc));
            check("rd_instr", 64'(rd_instr), 64'(mq[0].instr));
            check("rd_we", 64'(rd_we), 64'(mq[0].we));
            check("rd_waddr", 64'(rd_waddr), 64'(mq[0].waddr));
            check("rd_wdata", 64'(rd_wdata), 64'(mq[0].wdata));
`ifdef TRACE_TIMESTAMP_EN
            check("rd_stamp", 64'(rd_stamp), 64'(mq[0].stamp));
`endif
        end else begin
            check("rd_zero", {rd_pc, rd_instr, 3'b000, rd_we, rd_waddr, rd_wdata[15:0]}, 64'd0);
            check("rd_wdata_zero", 64'(rd_wdata), 64'd0);
`ifdef TRACE_TIMESTAMP_EN
            check("rd_stamp_zero", 64'(rd_stamp), 64'd0);
`endif
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic retire(input int pc);
        ret_valid = 1'b1;
        ret_pc    = PC_W'(pc);
        ret_instr = INSTR_W'($urandom);
        ret_we    = 1'($urandom);
        ret_waddr = 4'($urandom);
        ret_wdata = DATA_W'($urandom);
        step();
        ret_valid = 1'b0;
    endtask

    task automatic do_arm(input int tpc, input int pcnt);
        trig_pc  = PC_W'(tpc);
        post_cnt = 8'(pcnt);
        arm      = 1'b1;
        step();
        arm      = 1'b0;
    endtask

    logic [PC_W-1:0] first_pc;
    logic [PC_W-1:0] last_pc;

    initial begin
        rst       = 1'b1;
        ret_valid = 1'b0;
        ret_pc    = '0;
        ret_instr = '0;
        ret_we    = 1'b0;
        ret_waddr = '0;
        ret_wdata = '0;
        arm       = 1'b0;
        trig_pc   = '0;
        post_cnt  = '0;
        rd_ready  = 1'b0;

        // Two reset cycles, then retirements with no arm are ignored.
        step();
        step();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) retire(i);
        check("idle_state", 64'(state), 64'd0);
        check("idle_level", 64'(level), 64'd0);
        check("idle_rd_valid", 64'(rd_valid), 64'd0);
        check("idle_drop", 64'(drop_cnt), 64'd0);

        // Trigger mid-stream with three post-trigger captures.
        do_arm(32'h10, 3);
        for (int i = 0; i < 12; i++) retire(2 * i);
        check("t27_state", 64'(state), 64'd3);
        check("t27_level", 64'(level), 64'd12);
        first_pc = rd_pc;
        rd_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            last_pc = rd_pc;
            step();
        end
        rd_ready = 1'b0;
        check("t27_first", 64'(first_pc), 64'h00);
        check("t27_last", 64'(last_pc), 64'h16);

        // Wrap while armed, trigger with no post capture.
        do_arm(20, 0);
        for (int i = 0; i <= 20; i++) retire(i);
        check("t28_state", 64'(state), 64'd3);
        check("t28_level", 64'(level), 64'd16);
        check("t28_first", 64'(rd_pc), 64'd5);
        check("t28_drop", 64'(drop_cnt), 64'd0);

        // Full buffer in POST with no consumer: post captures are dropped.
        do_arm(20, 4);
        for (int i = 0; i <= 24; i++) retire(i);
        check("t29_drop", 64'(drop_cnt), 64'd4);
        check("t29_level", 64'(level), 64'd16);
        check("t29_state", 64'(state), 64'd3);

        // Drain to five entries, then arm together with retirement and pop.
        rd_ready = 1'b1;
        for (int i = 0; i < 11; i++) step();
        check("t30_pre_level", 64'(level), 64'd5);
        ret_valid = 1'b1;
        ret_pc    = 24'h7;
        trig_pc   = 24'h7;
        post_cnt  = 8'd0;
        do_arm(7, 0);
        ret_valid = 1'b0;
        rd_ready  = 1'b0;
        check("t30_state", 64'(state), 64'd1);
        check("t30_level", 64'(level), 64'd0);
        check("t30_rd_valid", 64'(rd_valid), 64'd0);

        // Full buffer in POST: pop and retirement together store, no drop.
        do_arm(20, 3);
        for (int i = 0; i <= 20; i++) retire(i);
        rd_ready = 1'b1;
        retire(21);
        rd_ready = 1'b0;
        check("t14_level", 64'(level), 64'd16);
        check("t14_drop", 64'(drop_cnt), 64'd0);
        check("t14_state", 64'(state), 64'd2);

`ifdef TRACE_TIMESTAMP_EN
        // Stamp of a retirement at cycle 7 after reset release.
        rst = 1'b1;
        step();
        rst = 1'b0;
        do_arm(32'h33, 0);
        for (int i = 0; i < 6; i++) step();
        retire(32'h33);
        check("stamp_7", 64'(rd_stamp), 64'd7);
`endif

        // Randomized traffic, including resets and re-arms mid-capture.
        for (int n = 0; n < 3000; n++) begin
            rst       = ($urandom_range(0, 199) == 0);
            arm       = ($urandom_range(0, 39) == 0);
            if (arm) begin
                trig_pc  = PC_W'($urandom_range(0, 15));
                post_cnt = 8'($urandom_range(0, 20));
            end
            ret_valid = ($urandom_range(0, 3) != 0);
            ret_pc    = PC_W'($urandom_range(0, 15));
            ret_instr = INSTR_W'($urandom);
            ret_we    = 1'($urandom);
            ret_waddr = 4'($urandom);
            ret_wdata = DATA_W'($urandom);
            rd_ready  = ($urandom_range(0, 2) == 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
